// File: rtl/control_fsm_if.sv
// Handshake bundle between the decoder/memory/interrupt side and control_fsm.
// Master drives the request side; the FSM (slave) drives the strobes and status.
interface control_fsm_if;
    logic       run;
    logic [2:0] op_class;
    logic       set_flags;
    logic       cond_pass;
    logic       mem_ready;
    logic       irq_req;
    logic       primask;

    logic       wr_en;
    logic       cu_decode;
    logic       ld_sp;
    logic       ld_lr;
    logic       ld_pc;
    logic       ld_rd;
    logic       ld_apsr;
    logic       ld_ipsr;
    logic       ld_primask;
    logic       fault;
    logic [5:0] exc_num;
    logic [2:0] state;

    modport master (
        output run, op_class, set_flags, cond_pass, mem_ready, irq_req, primask,
        input  wr_en, cu_decode, ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr,
               ld_primask, fault, exc_num, state
    );

    modport slave (
        input  run, op_class, set_flags, cond_pass, mem_ready, irq_req, primask,
        output wr_en, cu_decode, ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr,
               ld_primask, fault, exc_num, state
    );
endinterface

// File: rtl/control_fsm.sv
// Instruction sequencer: FETCH/DECODE/EXEC with optional MEM/WB, plus exception entry.
// All outputs decode from registered state and latched instruction fields only.
module control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    control_fsm_if.slave cif
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_EXC    = 3'd6
    } state_e;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ALU   = 3'd1;
    localparam logic [2:0] OP_LOAD  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_BR    = 3'd4;
    localparam logic [2:0] OP_BL    = 3'd5;
    localparam logic [2:0] OP_MSR   = 3'd6;
    localparam logic [2:0] OP_UNDEF = 3'd7;

    localparam logic [3:0] TO_LAST   = 4'(MEM_TIMEOUT - 1);
    localparam logic [5:0] EXC_FAULT = 6'd3;
    localparam logic [5:0] EXC_IRQ   = 6'd16;

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       sf_q, sf_d;
    logic       cp_q, cp_d;
    logic [3:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
    logic [5:0] exc_q, exc_d;

    logic end_now, flt;
    logic wr_en, cu_decode, ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            sf_q    <= 1'b0;
            cp_q    <= 1'b0;
            cnt_q   <= 4'd0;
            fault_q <= 1'b0;
            exc_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sf_q    <= sf_d;
            cp_q    <= cp_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sf_d       = sf_q;
        cp_d       = cp_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        exc_d      = exc_q;
        end_now    = 1'b0;
        flt        = 1'b0;
        wr_en      = 1'b0;
        cu_decode  = 1'b0;
        ld_sp      = 1'b0;
        ld_lr      = 1'b0;
        ld_pc      = 1'b0;
        ld_rd      = 1'b0;
        ld_apsr    = 1'b0;
        ld_ipsr    = 1'b0;
        ld_primask = 1'b0;

        case (state_q)
            S_IDLE: if (cif.run) state_d = S_FETCH;
            S_FETCH: begin
                ld_pc   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                cu_decode = 1'b1;
                state_d   = S_EXEC;
                op_d      = cif.op_class;
                sf_d      = cif.set_flags;
                cp_d      = cif.cond_pass;
            end
            S_EXEC: begin
                if (!cp_q) begin
                    end_now = 1'b1;
                end else begin
                    case (op_q)
                        OP_ALU: begin
                            ld_rd   = 1'b1;
                            ld_apsr = sf_q;
                            end_now = 1'b1;
                        end
                        OP_LOAD, OP_STORE: begin
                            state_d = S_MEM;
                            cnt_d   = 4'd0;
                        end
                        OP_BR: begin
                            ld_pc   = 1'b1;
                            end_now = 1'b1;
                        end
                        OP_BL: begin
                            ld_pc   = 1'b1;
                            ld_lr   = 1'b1;
                            end_now = 1'b1;
                        end
                        OP_MSR: begin
                            ld_primask = 1'b1;
                            end_now    = 1'b1;
                        end
                        OP_UNDEF: flt = 1'b1;
                        default:  end_now = 1'b1;
                    endcase
                end
            end
            S_MEM: begin
                wr_en = (op_q == OP_STORE);
                // A ready in the last allowed cycle still completes the access.
                if (cif.mem_ready) begin
                    if (op_q == OP_LOAD) state_d = S_WB;
                    else                 end_now = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == TO_LAST) flt = 1'b1;
                end
            end
            S_WB: begin
                ld_rd   = 1'b1;
                end_now = 1'b1;
            end
            S_EXC: begin
                ld_sp   = 1'b1;
                ld_lr   = 1'b1;
                ld_ipsr = 1'b1;
                ld_pc   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        // Faults outrank interrupts; interrupts are only considered at instruction end.
        if (flt) begin
            state_d = S_EXC;
            fault_d = 1'b1;
            exc_d   = EXC_FAULT;
        end else if (end_now) begin
            if (cif.irq_req && !cif.primask) begin
                state_d = S_EXC;
                exc_d   = EXC_IRQ;
            end else if (cif.run) begin
                state_d = S_FETCH;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    assign cif.wr_en      = wr_en;
    assign cif.cu_decode  = cu_decode;
    assign cif.ld_sp      = ld_sp;
    assign cif.ld_lr      = ld_lr;
    assign cif.ld_pc      = ld_pc;
    assign cif.ld_rd      = ld_rd;
    assign cif.ld_apsr    = ld_apsr;
    assign cif.ld_ipsr    = ld_ipsr;
    assign cif.ld_primask = ld_primask;
    assign cif.fault      = fault_q;
    assign cif.exc_num    = exc_q;
    assign cif.state      = state_q;
endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction expected cycle traces built from the
// instruction-level rules, driven by a vector table, random instructions and reset cases.
module tb_control_fsm;
    localparam int TO = 4;

    localparam logic [8:0] B_WR   = 9'h100;
    localparam logic [8:0] B_DEC  = 9'h080;
    localparam logic [8:0] B_SP   = 9'h040;
    localparam logic [8:0] B_LR   = 9'h020;
    localparam logic [8:0] B_PC   = 9'h010;
    localparam logic [8:0] B_RD   = 9'h008;
    localparam logic [8:0] B_APSR = 9'h004;
    localparam logic [8:0] B_IPSR = 9'h002;
    localparam logic [8:0] B_PM   = 9'h001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_fsm_if cif();
    control_fsm #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .cif(cif));

    int checks = 0;
    int errors = 0;
    logic       m_fault;
    logic [5:0] m_exc;

    typedef struct {
        logic [2:0] op;
        logic       s, cp;
        int         lat;
        logic       irq, pm, rn;
        int         exp_mem;
        logic [2:0] exp_nxt;
    } vec_t;

    function automatic logic [8:0] stb_now();
        return {cif.wr_en, cif.cu_decode, cif.ld_sp, cif.ld_lr, cif.ld_pc,
                cif.ld_rd, cif.ld_apsr, cif.ld_ipsr, cif.ld_primask};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare the current cycle's {state, strobes, fault, exc_num}, then advance one clock.
    task automatic cyc(input string nm, input logic [2:0] st, input logic [8:0] stb);
        chk(nm, {13'd0, cif.state, stb_now(), cif.fault, cif.exc_num},
                {13'd0, st, stb, m_fault, m_exc});
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        cif.run       = 1'($urandom);
        cif.op_class  = 3'($urandom);
        cif.set_flags = 1'($urandom);
        cif.cond_pass = 1'($urandom);
        cif.mem_ready = 1'($urandom);
        cif.irq_req   = 1'($urandom);
        cif.primask   = 1'($urandom);
    endtask

    task automatic drive_end(input logic irq, input logic pm, input logic rn);
        cif.irq_req = irq;
        cif.primask = pm;
        cif.run     = rn;
    endtask

    // Expects the DUT in FETCH; returns it to FETCH. lat = MEM cycle carrying mem_ready (0 = never).
    task automatic run_instr(input logic [2:0] op, input logic s, input logic cp, input int lat,
                             input logic irq, input logic pm, input logic rn,
                             output int n_mem, output logic [2:0] nxt);
        logic [8:0] exp_stb;
        logic       go_mem, flt;
        n_mem = 0;
        noise();
        cyc("fetch", 3'd1, B_PC);
        noise();
        cif.op_class = op; cif.set_flags = s; cif.cond_pass = cp;
        cyc("decode", 3'd2, B_DEC);

        exp_stb = 9'h0;
        if (cp) begin
            case (op)
                3'd1: exp_stb = B_RD | (s ? B_APSR : 9'h0);
                3'd4: exp_stb = B_PC;
                3'd5: exp_stb = B_PC | B_LR;
                3'd6: exp_stb = B_PM;
                default: exp_stb = 9'h0;
            endcase
        end
        go_mem = cp && (op == 3'd2 || op == 3'd3);
        flt    = cp && (op == 3'd7);
        noise();
        if (!go_mem && !flt) drive_end(irq, pm, rn);
        cyc("exec", 3'd3, exp_stb);

        if (go_mem) begin
            for (int k = 1; k <= TO; k++) begin
                noise();
                cif.mem_ready = (k == lat);
                if (k == lat && op == 3'd3) drive_end(irq, pm, rn);
                if (cif.state == 3'd4) n_mem++;
                cyc("mem", 3'd4, (op == 3'd3) ? B_WR : 9'h0);
                if (k == lat || k == TO) begin
                    if (k != lat) flt = 1'b1;
                    else if (op == 3'd2) begin
                        noise();
                        drive_end(irq, pm, rn);
                        cyc("wb", 3'd5, B_RD);
                    end
                    break;
                end
            end
        end

        nxt = cif.state;
        if (flt || (irq && !pm)) begin
            if (flt) begin
                m_fault = 1'b1;
                m_exc   = 6'd3;
            end else begin
                m_exc   = 6'd16;
            end
            noise();
            cyc("exc", 3'd6, B_SP | B_LR | B_IPSR | B_PC);
        end else if (!rn) begin
            noise();
            cif.run = 1'b0;
            cyc("idle_hold", 3'd0, 9'h0);
            cif.run = 1'b1;
            cyc("idle_go", 3'd0, 9'h0);
        end
    endtask

    initial begin
        vec_t       tbl[13];
        int         n_mem;
        logic [2:0] nxt;

        //          op    s     cp    lat irq   pm    rn    mem nxt
        tbl[0]  = '{3'd1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 0, 3'd1};
        tbl[1]  = '{3'd2, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 3, 3'd1};
        tbl[2]  = '{3'd3, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 4, 3'd6};
        tbl[3]  = '{3'd4, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b1, 0, 3'd1};
        tbl[4]  = '{3'd4, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 0, 3'd6};
        tbl[5]  = '{3'd5, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 3'd1};
        tbl[6]  = '{3'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 3'd0};
        tbl[7]  = '{3'd3, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1, 4, 3'd6};
        tbl[8]  = '{3'd7, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 0, 3'd6};
        tbl[9]  = '{3'd6, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 0, 3'd1};
        tbl[10] = '{3'd7, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 3'd1};
        tbl[11] = '{3'd2, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1, 3'd0};
        tbl[12] = '{3'd1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 0, 3'd1};

        m_fault = 1'b0;
        m_exc   = 6'd0;
        cif.run = 1'b0; cif.op_class = 3'd0; cif.set_flags = 1'b0; cif.cond_pass = 1'b0;
        cif.mem_ready = 1'b0; cif.irq_req = 1'b0; cif.primask = 1'b0;

        #1;
        chk("reset_state", {13'd0, cif.state, stb_now(), cif.fault, cif.exc_num}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("idle_run0_a", 3'd0, 9'h0);
        cyc("idle_run0_b", 3'd0, 9'h0);
        cif.run = 1'b1;
        cyc("idle_run1", 3'd0, 9'h0);

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].s, tbl[i].cp, tbl[i].lat, tbl[i].irq, tbl[i].pm,
                      tbl[i].rn, n_mem, nxt);
            chk($sformatf("tbl%0d_mem_cycles", i), n_mem, tbl[i].exp_mem);
            chk($sformatf("tbl%0d_next_state", i), {29'd0, nxt}, {29'd0, tbl[i].exp_nxt});
        end

        for (int r = 0; r < 300; r++) begin
            run_instr(3'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 3) != 0),
                      $urandom_range(0, TO + 1), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) != 0), n_mem, nxt);
        end

        // Reset in the middle of a STORE's MEM visit must drop wr_en without a clock edge.
        noise();
        cyc("rst_fetch", 3'd1, B_PC);
        noise();
        cif.op_class = 3'd3; cif.cond_pass = 1'b1;
        cyc("rst_decode", 3'd2, B_DEC);
        noise();
        cyc("rst_exec", 3'd3, 9'h0);
        cif.mem_ready = 1'b0;
        chk("rst_mem_wr_before", {31'd0, cif.wr_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_wr_en", {31'd0, cif.wr_en}, 32'd0);
        chk("rst_async_all", {13'd0, cif.state, stb_now(), cif.fault, cif.exc_num}, 32'd0);
        m_fault = 1'b0;
        m_exc   = 6'd0;
        cif.run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_rst_idle", 3'd0, 9'h0);
        cif.run = 1'b1;
        cyc("post_rst_go", 3'd0, 9'h0);
        run_instr(3'd1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, n_mem, nxt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, meaning the maximum number of cycles spent in MEM before a fault is raised; legal range 1..15.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low: asserted when 0.
REQ-004 run  in  1  allow fetch of the next instruction.
REQ-005 op_class  in  3  instruction class from decoder: 0 NOP, 1 ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 BRANCH_LINK, 6 MSR_PRIMASK, 7 UNDEF.
REQ-006 set_flags  in  1  S bit of the decoded instruction.
REQ-007 cond_pass  in  1  condition check of the decoded instruction against the current flags.
REQ-008 mem_ready  in  1  memory access complete.
REQ-009 irq_req  in  1  level interrupt request.
REQ-010 primask  in  1  current PRIMASK; when 1, irq_req is ignored.
REQ-011 Control strobe outputs, each 1 bit: wr_en, cu_decode, ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask.
REQ-012 fault  out  1  sticky fault indicator.
REQ-013 exc_num  out  6  exception number presented with ld_ipsr.
REQ-014 state  out  3  current state encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, EXC 6.

Function
REQ-015 All outputs SHALL be decoded only from the state register and internally latched fields, with no combinational path from any input to any output.
REQ-016 op_class, set_flags and cond_pass SHALL be latched on the clock edge that leaves DECODE, and the latched values SHALL be used in EXEC, MEM and WB.
REQ-017 IDLE: all strobes 0; next state is FETCH if run=1, otherwise IDLE.
REQ-018 FETCH: ld_pc=1 for exactly one cycle; next state is DECODE.
REQ-019 DECODE: cu_decode=1 for exactly one cycle; next state is EXEC.
REQ-020 EXEC with cond_pass=0 SHALL assert no strobes and take the END transition.
REQ-021 EXEC actions by op_class, each followed by END unless noted:
- NOP: no strobe.
- ALU: ld_rd=1, and ld_apsr=set_flags.
- LOAD: no strobe; go to MEM.
- STORE: no strobe; go to MEM.
- BRANCH: ld_pc=1.
- BRANCH_LINK: ld_pc=1 and ld_lr=1 in the same cycle.
- MSR_PRIMASK: ld_primask=1.
- UNDEF: no strobe; go to EXC with a fault.
REQ-022 MEM: wr_en=1 in every MEM cycle for STORE and 0 for LOAD.
REQ-023 MEM exit rules:
- mem_ready=1 with LOAD: go to WB.
- mem_ready=1 with STORE: take END.
REQ-024 MEM timeout counter:
- 4-bit, cleared on entry to MEM.
- Increments on each MEM cycle with mem_ready=0.
- If mem_ready=0 while counter == MEM_TIMEOUT-1, go to EXC with a fault.
- mem_ready=1 in that same cycle SHALL take priority over the timeout.
REQ-025 WB: ld_rd=1 for one cycle; then take END.
REQ-026 END transition, evaluated in the completing cycle:
- irq_req=1 and primask=0: go to EXC with exc_num=16.
- Otherwise run=1: go to FETCH.
- Otherwise: go to IDLE.
REQ-027 Interrupts SHALL be sampled only at END, never in the middle of an instruction.
REQ-028 Fault entry (UNDEF or timeout) SHALL set fault=1 and exc_num=3; a fault SHALL take priority over a simultaneous irq_req.
REQ-029 EXC: ld_sp, ld_lr, ld_ipsr and ld_pc all =1 for exactly one cycle; next state is FETCH regardless of run.
REQ-030 exc_num SHALL hold its value until the next EXC entry.
REQ-031 fault SHALL remain 1 until reset.
REQ-032 Every strobe SHALL be a single-cycle pulse per state visit, except wr_en, which is held for the whole MEM visit.

Reset
REQ-033 While rst=0, immediately and asynchronously:
- state=IDLE.
- All strobes=0.
- fault=0, exc_num=0.
- Timeout counter=0 and latched fields=0.
REQ-034 Reset asserted during MEM SHALL drop wr_en within the same cycle, without waiting for a clock edge.
REQ-035 After rst returns to 1, the first FETCH SHALL occur on the first edge that sees run=1.

Verification
REQ-036 ALU sequence: run=1, op=1, S=1, cond_pass=1, irq_req=0 -> states 1,2,3,1; ld_pc in cycle 1, cu_decode in cycle 2, ld_rd=ld_apsr=1 in cycle 3.
REQ-037 Load: op=2, mem_ready asserted on the 3rd MEM cycle -> 3 MEM cycles with wr_en=0, then WB with ld_rd=1, then FETCH.
REQ-038 Store timeout: op=3, mem_ready=0, MEM_TIMEOUT=4 -> exactly 4 MEM cycles with wr_en=1, then EXC with ld_sp=ld_lr=ld_ipsr=ld_pc=1, exc_num=3, fault=1 sticky.
REQ-039 Interrupt gating at END of a BRANCH:
- irq_req=1, primask=1 -> next state FETCH, no EXC.
- Repeat with primask=0 -> EXC with exc_num=16, then FETCH.
REQ-040 Flow edge cases:
- cond_pass=0 on op=5 -> no ld_pc or ld_lr pulse.
- run=0 at END -> state IDLE, all strobes 0.
- rst pulsed low mid-MEM -> wr_en=0 immediately and state=0.
